// File: rtl/final_soc_pio_pkg.sv
// Shared definitions for the SoC PIO blocks: register map, status bit
// positions and the pulse-timer state encoding.
package final_soc_pio_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_SET   = 2'd1;
  localparam logic [1:0] REG_CLEAR = 2'd2;
  localparam logic [1:0] REG_PULSE = 2'd3;

  localparam int STAT_BUSY    = 31;
  localparam int STAT_OVERRUN = 30;

  typedef enum logic {
    PULSE_IDLE,
    PULSE_ACTIVE
  } pulse_state_e;

  // Width of a down-counter that must hold the value len without wrapping.
  function automatic int cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/final_soc_pio_pulse_timer.sv
// Hardware-timed pulse FSM for the USB control PIO. A start while idle
// arms a PULSE_LEN-cycle window (busy); a start while already busy is
// rejected and reported on overrun_set so the parent can latch it.
module final_soc_pio_pulse_timer
  import final_soc_pio_pkg::*;
#(
  parameter int PULSE_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic overrun_set
);

  localparam int CW = cnt_width(PULSE_LEN);

  pulse_state_e   state;
  logic [CW-1:0]  cnt;

  // Idle/active sequencing with the down-counter; busy is a registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PULSE_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        PULSE_IDLE: begin
          if (start) begin
            state <= PULSE_ACTIVE;
            cnt   <= CW'(PULSE_LEN);
            busy  <= 1'b1;
          end
        end
        PULSE_ACTIVE: begin
          // The cycle that sees a count of 1 is the last pulse cycle.
          if (cnt == CW'(1)) begin
            state <= PULSE_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= PULSE_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A start request arriving mid-pulse is dropped; flag it for the sticky bit.
  assign overrun_set = start && busy;

endmodule

// File: rtl/final_soc_usb_ctl_pio.sv
// Avalon-MM output PIO driving the USB controller strobes. Holds a base
// word with atomic set/clear and, when FINAL_SOC_USB_CTL_PULSE_EN is
// defined, a hardware-timed pulse that inverts masked bits for PULSE_LEN
// cycles. Without the macro, address 3 is inert and out_port = base.
module final_soc_usb_ctl_pio
  import final_soc_pio_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0,
  parameter int          PULSE_LEN   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] mask_eff;
  logic [31:0]      base_ext;
  logic [31:0]      status;
  logic             unused_wd;

  assign wr        = chipselect && !write_n;
  assign rd        = chipselect && write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata[31:WIDTH];

  // Base word: replace, atomic OR, atomic AND-NOT.
  always_ff @(posedge clk) begin
    if (reset) begin
      base <= RST_V;
    end else if (wr) begin
      case (address)
        REG_DATA:  base <= wd;
        REG_SET:   base <= base | wd;
        REG_CLEAR: base <= base & ~wd;
        default:   base <= base;
      endcase
    end
  end

`ifdef FINAL_SOC_USB_CTL_PULSE_EN
  logic             pulse_wr;
  logic             busy;
  logic             overrun_set;
  logic             overrun;
  logic [WIDTH-1:0] mask;

  assign pulse_wr = wr && (address == REG_PULSE);

  final_soc_pio_pulse_timer #(
    .PULSE_LEN (PULSE_LEN)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (pulse_wr),
    .busy        (busy),
    .overrun_set (overrun_set)
  );

  // Mask is captured only for an accepted start and dropped once idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
    end else if (pulse_wr && !busy) begin
      mask <= wd;
    end else if (!busy) begin
      mask <= '0;
    end
  end

  // Sticky overrun; set has priority over the read-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (rd && (address == REG_PULSE)) begin
      overrun <= 1'b0;
    end
  end

  assign mask_eff = busy ? mask : '0;

  // Status word layout: busy and overrun in the top two bits.
  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = busy;
    status[STAT_OVERRUN] = overrun;
  end
`else
  assign mask_eff = '0;
  assign status   = '0;
`endif

  // Zero-extend the base word for readback.
  always_comb begin
    base_ext              = '0;
    base_ext[WIDTH-1:0]   = base;
  end

  // Registered output pins: base with the active pulse mask applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= RST_V;
    end else begin
      out_port <= base ^ mask_eff;
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd) begin
      case (address)
        REG_DATA:  readdata <= base_ext;
        REG_PULSE: readdata <= status;
        default:   readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_final_soc_usb_ctl_pio.sv
// Self-checking bench for final_soc_usb_ctl_pio (WIDTH=4, RESET_VALUE=4'hA,
// PULSE_LEN=16). A time-window reference model is compared every cycle;
// directed sequences pin the model with literal expectations, then a
// random phase exercises register accesses and mid-stream resets.
module tb_final_soc_usb_ctl_pio;

  localparam int          WIDTH = 4;
  localparam int unsigned RV    = 4'hA;
  localparam int          PL    = 16;
`ifdef FINAL_SOC_USB_CTL_PULSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  final_soc_usb_ctl_pio #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV),
    .PULSE_LEN   (PL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Reference model: a pulse accepted at edge T is "live" for edges
  // T+1..T+PL (those edges see the mask applied to the output register).
  int               edge_n  = 0;
  int               p_start = -1000;
  logic [WIDTH-1:0] m_base  = '0;
  logic [WIDTH-1:0] m_mask  = '0;
  logic             m_ovr   = 1'b0;
  logic [WIDTH-1:0] exp_out = '0;
  logic [31:0]      exp_rd  = '0;

  always @(posedge clk) begin
    bit live;
    edge_n = edge_n + 1;
    live = PEN && (edge_n > p_start) && (edge_n <= p_start + PL);
    if (reset) begin
      m_base  = WIDTH'(RV);
      m_mask  = '0;
      m_ovr   = 1'b0;
      p_start = -1000;
      exp_out = WIDTH'(RV);
      exp_rd  = '0;
    end else begin
      exp_out = m_base ^ (live ? m_mask : '0);
      if (chipselect && write_n) begin
        if (address == 2'd0) exp_rd = 32'(m_base);
        else if (address == 2'd3 && PEN) begin
          exp_rd = {live, m_ovr, 30'b0};
          m_ovr  = 1'b0;
        end else exp_rd = '0;
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_base = writedata[WIDTH-1:0];
          2'd1: m_base = m_base | writedata[WIDTH-1:0];
          2'd2: m_base = m_base & ~writedata[WIDTH-1:0];
          default: begin
            if (PEN) begin
              if (live) m_ovr = 1'b1;
              else begin
                p_start = edge_n;
                m_mask  = writedata[WIDTH-1:0];
              end
            end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk = n_chk + 2;
      if (out_port !== exp_out) begin
        n_fail = n_fail + 1;
        $display("FAIL model_out at edge %0d: got %h expected %h", edge_n, out_port, exp_out);
      end
      if (readdata !== exp_rd) begin
        n_fail = n_fail + 1;
        $display("FAIL model_rd at edge %0d: got %h expected %h", edge_n, readdata, exp_rd);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w,
                      input logic [1:0] a, input logic [31:0] d);
    reset      = r;
    chipselect = c;
    write_n    = w;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rdreg(input logic [1:0] a);
    step(1'b0, 1'b1, 1'b1, a, 32'h0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    chk_en = 1'b1;
    chk("reset_out", 32'(out_port), 32'hA);
    chk("reset_rd", readdata, 32'h0);
    rdreg(2'd3);
    chk("reset_status", readdata, 32'h0);

    wr(2'd0, 32'hFFFF_FFF5);
    chk("data_latency", 32'(out_port), 32'hA);
    idle();
    chk("data_out", 32'(out_port), 32'h5);
    wr(2'd1, 32'h8);
    idle();
    chk("set_out", 32'(out_port), 32'hD);
    wr(2'd2, 32'h1);
    idle();
    chk("clear_out", 32'(out_port), 32'hC);
    rdreg(2'd0);
    chk("data_read", readdata, 32'hC);
    rdreg(2'd1);
    chk("set_read", readdata, 32'h0);

`ifdef FINAL_SOC_USB_CTL_PULSE_EN
    wr(2'd0, 32'h0);
    idle();
    // Basic 16-cycle pulse with a mid-pulse status read.
    wr(2'd3, 32'h1);
    chk("pulse_start_lat", 32'(out_port), 32'h0);
    for (int i = 1; i <= 17; i++) begin
      if (i == 8) rdreg(2'd3); else idle();
      chk("pulse_out", 32'(out_port), (i <= 16) ? 32'h1 : 32'h0);
      if (i == 8) chk("busy_mid", readdata, 32'h8000_0000);
    end
    rdreg(2'd3);
    chk("busy_after", readdata, 32'h0);

    // Second PULSE write mid-pulse is ignored and flags overrun.
    wr(2'd3, 32'h1);
    for (int i = 1; i <= 17; i++) begin
      if (i == 5) wr(2'd3, 32'h2); else idle();
      chk("ovr_pulse_out", 32'(out_port), (i <= 16) ? 32'h1 : 32'h0);
    end
    rdreg(2'd3);
    chk("ovr_read", readdata, 32'h4000_0000);
    rdreg(2'd3);
    chk("ovr_cleared", readdata, 32'h0);

    // SET during an active pulse shows through the mask.
    wr(2'd3, 32'h1);
    for (int i = 1; i <= 17; i++) begin
      if (i == 4) wr(2'd1, 32'h4); else idle();
      chk("set_in_pulse", 32'(out_port),
          (i > 16) ? 32'h4 : ((i >= 5) ? 32'h5 : 32'h1));
    end

    // Reset aborts a pulse; a new pulse runs the full length.
    wr(2'd3, 32'h1);
    idle();
    idle();
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    chk("abort_out", 32'(out_port), 32'hA);
    rdreg(2'd3);
    chk("abort_status", readdata, 32'h0);
    wr(2'd3, 32'h1);
    for (int i = 1; i <= 17; i++) begin
      idle();
      chk("repulse_out", 32'(out_port), (i <= 16) ? 32'hB : 32'hA);
    end
`else
    wr(2'd3, 32'hF);
    idle();
    chk("pulse_ignored", 32'(out_port), 32'hC);
    rdreg(2'd3);
    chk("status_zero", readdata, 32'h0);
`endif

    // Random phase: model comparison runs every cycle.
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/final_soc_usb_ctl_pio.md
# final_soc_usb_ctl_pio

Avalon-MM output PIO that drives the USB controller's control strobes (reset, chip-select and similar lines) from the Nios II. It is the write-side counterpart of the read-only GPX input PIO. It holds a software-written output word with atomic bit set and clear. It can also invert selected bits for a fixed, hardware-timed pulse so firmware never times strobes in software.

## Interface
Parameters:
- WIDTH, 4: width of out_port, 1..30.
- RESET_VALUE, 0: out_port value during and after reset.
- PULSE_LEN, 16: pulse duration in clk cycles, at least 1.

Ports:
- clk, input, 1: single system clock. All logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- address, input, 2: register select.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe, qualified by chipselect.
- writedata, input, 32: write data. Only bits [WIDTH-1:0] are used.
- readdata, output, 32: registered read data.
- out_port, output, WIDTH: registered output to the USB control pins.

## Operation
- Registers:
  - 0 DATA: write replaces the base word; read returns the base word.
  - 1 SET: write ORs writedata into the base word; read returns 0.
  - 2 CLEAR: write clears the base word where writedata is 1; read returns 0.
  - 3 PULSE: write starts a pulse with mask = writedata[WIDTH-1:0]; read returns {busy, overrun, 30'b0}.
- A write is chipselect=1 and write_n=0. A read is any cycle with chipselect=1 and write_n=1.
- out_port = base ^ (busy ? mask : 0), registered.
- Pulse FSM:
  - IDLE to ACTIVE on a PULSE write. This latches the mask and loads the counter with PULSE_LEN.
  - ACTIVE: the counter decrements every cycle. When the counter equals 1, the FSM returns to IDLE and the mask clears.
- A PULSE write while ACTIVE is ignored: the pulse and mask are unchanged and the sticky overrun bit is set.
  - A read of address 3 clears overrun. If the set and the clear happen in the same cycle, the set wins.
- DATA, SET and CLEAR writes during ACTIVE update the base word. out_port reflects the new base, still XORed with the mask.
- A PULSE write with mask 0 still runs the FSM: busy is set, out_port does not change.
- Counter width is $clog2(PULSE_LEN+1). It never wraps.
- Unused high bits of writedata are ignored. The base word is WIDTH bits, zero-extended on readback.

## Timing
- Reset values:
  - base = RESET_VALUE and out_port = RESET_VALUE.
  - readdata = 0.
  - FSM in IDLE, mask = 0, busy = 0, overrun = 0.
- Reset asserted mid-pulse aborts the pulse. out_port = RESET_VALUE on the first cycle after the reset edge.
- Write latency: a write sampled at edge T is visible on out_port after edge T+1.
- Pulse: a PULSE write at edge T gives out_port = base^mask for exactly PULSE_LEN cycles, starting after edge T+1. out_port returns to base after edge T+1+PULSE_LEN.
- busy reads 1 from the cycle after the write through the last pulse cycle.
- Read latency is 1. readdata is valid the cycle after the chipselect read and holds until the next read.
- No waitrequest: every access completes in one cycle.

## Configuration
- FINAL_SOC_USB_CTL_PULSE_EN
  - Defined: PULSE register, FSM, counter and status bits are present as described above.
  - Undefined: writes to address 3 are ignored, reads of address 3 return 0, and out_port = base. No counter logic is synthesised.

## Structure
- Shared package final_soc_pio_pkg holds:
  - register offset constants REG_DATA=0, REG_SET=1, REG_CLEAR=2, REG_PULSE=3;
  - status bit positions STAT_BUSY=31 and STAT_OVERRUN=30;
  - the pulse FSM state enum {PULSE_IDLE, PULSE_ACTIVE}.
- One sub-module, final_soc_pio_pulse_timer: the FSM plus the down-counter.
  - Inputs: start, PULSE_LEN parameter.
  - Outputs: busy, overrun_set.
  - Instantiated only under FINAL_SOC_USB_CTL_PULSE_EN.

## Test plan
- Reset with RESET_VALUE=4'b1010 -> out_port=4'b1010, readdata=0, address 3 reads 0.
- Write DATA=0x5, then SET 0x8, then CLEAR 0x1 -> out_port goes 0x5, 0xD, 0xC, each one cycle after its write; DATA read returns 0xC.
- DATA=0x0, PULSE_LEN=16, PULSE write mask=0x1 -> out_port=0x1 for exactly 16 cycles, then 0x0; address 3 reads busy=1 mid-pulse and 0 after.
- Second PULSE write at pulse cycle 5 -> pulse still ends at cycle 16; status reads overrun=1; the following status read shows overrun=0.
- SET 0x4 during an active pulse with mask=0x1 -> out_port=0x5 until the pulse ends, then 0x4.
- Reset asserted at pulse cycle 3 -> out_port=RESET_VALUE next cycle, busy=0; a new PULSE write afterwards runs the full 16 cycles.
